mix_unit_arbiter: RTL and testbench

//  Shares one add-and-XOR mixing datapath between two requesters (A, B).

---
 rtl/mix_unit_arbiter.sv | 106 ++++++++++
 tb/tb_mix_unit_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mix_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a shared add-and-XOR mixer.
// Each grant runs IDLE -> ADD -> MIX; the mixing key is the previous operand.
module mix_unit_arbiter #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       ADD_CONST = 17,
    parameter logic [WIDTH-1:0]  CLEAR_KEY = 8'h03
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             a_req,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ack,
    input  logic             b_req,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ack,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             result_id,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ADD_K = WIDTH'(ADD_CONST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        MIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] result_q;
    logic             result_valid_q;
    logic             result_id_q;
    logic             grant_id_q;
    logic             last_grant_q;
    logic             a_ack_q;
    logic             b_ack_q;

    logic             any_req_d;
    logic             grant_b_d;
    logic [WIDTH-1:0] win_data_d;

    // On a tie, B wins only if A was granted last (last_grant: 0 = A, 1 = B).
    always_comb begin
        any_req_d  = a_req | b_req;
        grant_b_d  = b_req & (~a_req | ~last_grant_q);
        win_data_d = grant_b_d ? b_data : a_data;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q        <= IDLE;
            operand_q      <= '0;
            sum_q          <= '0;
            key_q          <= CLEAR_KEY;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= 1'b0;
            grant_id_q     <= 1'b0;
            last_grant_q   <= 1'b1;
            a_ack_q        <= 1'b0;
            b_ack_q        <= 1'b0;
        end else begin
            a_ack_q        <= 1'b0;
            b_ack_q        <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        operand_q    <= win_data_d;
                        grant_id_q   <= grant_b_d;
                        last_grant_q <= grant_b_d;
                        a_ack_q      <= ~grant_b_d;
                        b_ack_q      <= grant_b_d;
                        state_q      <= ADD;
                    end
                end
                ADD: begin
                    sum_q   <= operand_q + ADD_K;
                    state_q <= MIX;
                end
                MIX: begin
                    result_q       <= sum_q ^ operand_q ^ key_q;
                    result_id_q    <= grant_id_q;
                    result_valid_q <= 1'b1;
                    key_q          <= operand_q;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_ack        = a_ack_q;
    assign b_ack        = b_ack_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mix_unit_arbiter.sv
// Directed bench for mix_unit_arbiter: single ops, wrap, ties,
// reset while busy and long idle, with hand-computed results.
module tb_mix_unit_arbiter;

    logic       clk;
    logic       clear_n;
    logic       a_req;
    logic [7:0] a_data;
    logic       a_ack;
    logic       b_req;
    logic [7:0] b_data;
    logic       b_ack;
    logic [7:0] result;
    logic       result_valid;
    logic       result_id;
    logic       busy;

    int checks;
    int errors;

    mix_unit_arbiter #(
        .WIDTH     (8),
        .ADD_CONST (17),
        .CLEAR_KEY (8'h03)
    ) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .a_req        (a_req),
        .a_data       (a_data),
        .a_ack        (a_ack),
        .b_req        (b_req),
        .b_data       (b_data),
        .b_ack        (b_ack),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    // Present one request, wait (bounded) for its ack, then check the result.
    task automatic run_op(input string tag, input logic is_b,
                          input logic [7:0] data, input logic [7:0] exp_res);
        bit seen;
        seen = 1'b0;
        if (is_b) begin
            b_req  = 1'b1;
            b_data = data;
        end else begin
            a_req  = 1'b1;
            a_data = data;
        end
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = is_b ? b_ack : a_ack;
        end
        check({tag, "_ack"}, 32'(seen), 32'd1);
        check({tag, "_other_ack"}, 32'(is_b ? a_ack : b_ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        check({tag, "_early_valid"}, 32'(result_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_id"}, 32'(result_id), 32'(is_b));
        @(negedge clk);
        check({tag, "_valid_pulse"}, 32'(result_valid), 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(exp_res));
    endtask

    logic [7:0] tie_res [4];
    logic       tie_id  [4];

    initial begin
        checks  = 0;
        errors  = 0;
        clear_n = 1'b0;
        a_req   = 1'b0;
        b_req   = 1'b0;
        a_data  = 8'h00;
        b_data  = 8'h00;

        do_reset();
        check("rst_result", 32'(result), 32'h00);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_id", 32'(result_id), 32'd0);
        check("rst_a_ack", 32'(a_ack), 32'd0);
        check("rst_b_ack", 32'(b_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        run_op("t1_a10", 1'b0, 8'h10, 8'h32);
        run_op("t2_b05", 1'b1, 8'h05, 8'h03);

        do_reset();
        run_op("t3_wrap", 1'b0, 8'hF0, 8'hF2);

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("t6_busy", 32'(busy), 32'd0);
            check("t6_valid", 32'(result_valid), 32'd0);
            check("t6_acks", 32'({a_ack, b_ack}), 32'd0);
            check("t6_hold", 32'(result), 32'hF2);
        end

        // Tie: A=10, B=05 held; keys go 03,10,05,10.
        tie_res[0] = 8'h32; tie_id[0] = 1'b0;
        tie_res[1] = 8'h03; tie_id[1] = 1'b1;
        tie_res[2] = 8'h34; tie_id[2] = 1'b0;
        tie_res[3] = 8'h03; tie_id[3] = 1'b1;
        do_reset();
        a_data = 8'h10;
        b_data = 8'h05;
        a_req  = 1'b1;
        b_req  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("t4_a_ack", 32'(a_ack), 32'(c == 1 || c == 7));
            check("t4_b_ack", 32'(b_ack), 32'(c == 4 || c == 10));
            check("t4_valid", 32'(result_valid), 32'(c % 3 == 0));
            if (c % 3 == 0) begin
                check("t4_id", 32'(result_id), 32'(tie_id[c/3-1]));
                check("t4_result", 32'(result), 32'(tie_res[c/3-1]));
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;

        // Reset while in ADD; result was 03 before.
        a_req  = 1'b1;
        a_data = 8'h10;
        @(negedge clk);
        check("t5_ack", 32'(a_ack), 32'd1);
        a_req = 1'b0;
        #2;
        clear_n = 1'b0;
        #1;
        check("t5_async_ack", 32'(a_ack), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_result", 32'(result), 32'h00);
        @(negedge clk);
        clear_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_no_valid", 32'(result_valid), 32'd0);
            check("t5_no_ack", 32'({a_ack, b_ack}), 32'd0);
        end
        run_op("t5_again", 1'b0, 8'h10, 8'h32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
